// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - per-button synchronizer, debouncer and press/release edge pulses
// Optional auto-repeat of btn_press while held: define BTN_AUTO_REPEAT_EN.
module btn_conditioner #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] s1_q, s2_q;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [N_BTN-1:0] accept;
  logic [CW-1:0]    cnt_q [N_BTN];
  logic [CW-1:0]    cnt_d [N_BTN];

`ifdef BTN_AUTO_REPEAT_EN
  localparam int HW = $clog2(REPEAT_DELAY + 1);
  localparam logic [HW-1:0] HOLD_FIRE   = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [HW-1:0] hold_q [N_BTN];
  logic [HW-1:0] hold_d [N_BTN];
`endif

  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      accept[i]    = 1'b0;
      cnt_d[i]     = '0;
      if (s2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          accept[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
      level_d[i]   = accept[i] ? s2_q[i] : level_q[i];
      press_d[i]   = accept[i] & s2_q[i];
      release_d[i] = accept[i] & ~s2_q[i];
`ifdef BTN_AUTO_REPEAT_EN
      // An accepted edge (either direction) takes priority, so a repeat never lands on a release.
      hold_d[i] = '0;
      if (level_q[i] && !accept[i]) begin
        if (hold_q[i] == HOLD_FIRE) begin
          press_d[i] = 1'b1;
          hold_d[i]  = HOLD_RELOAD;
        end else begin
          hold_d[i]  = hold_q[i] + 1'b1;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
`ifdef BTN_AUTO_REPEAT_EN
        hold_q[i] <= '0;
`endif
      end
    end else begin
      s1_q      <= btn_raw;
      s2_q      <= s1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
`ifdef BTN_AUTO_REPEAT_EN
        hold_q[i] <= hold_d[i];
`endif
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - scoreboard bench for btn_conditioner against a sample-window reference model
module tb_btn_conditioner;
  localparam int N  = 5;
  localparam int DC = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level, btn_press, btn_release;

  always #5 clk = ~clk;

  btn_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  typedef struct packed {
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mod_e;
  exp_t         mon_e;
  int           checks = 0;
  int           passed = 0;

  // Reference: a bit flips once the last DC synchronized samples all disagree with its level.
  logic [N-1:0] raw_hist[$];
  logic [N-1:0] m_level = '0;
  int           age[N];
  logic         all_diff;
  logic         samp;

  always @(posedge clk) begin
    mod_e = '0;
    if (!rst_n) begin
      raw_hist.delete();
      m_level = '0;
      for (int b = 0; b < N; b++) age[b] = 0;
    end else begin
      raw_hist.push_front(btn_raw);
      for (int b = 0; b < N; b++) begin
        all_diff = 1'b1;
        for (int k = 2; k <= DC + 1; k++) begin
          samp = (k < raw_hist.size()) ? raw_hist[k][b] : 1'b0;
          if (samp == m_level[b]) all_diff = 1'b0;
        end
        if (all_diff) begin
          if (m_level[b]) mod_e.rel[b] = 1'b1;
          else            mod_e.press[b] = 1'b1;
          m_level[b] = ~m_level[b];
          age[b] = 0;
        end else if (m_level[b]) begin
          age[b]++;
`ifdef BTN_AUTO_REPEAT_EN
          if (age[b] >= RD && (age[b] - RD) % RP == 0) mod_e.press[b] = 1'b1;
`endif
        end else begin
          age[b] = 0;
        end
      end
      if (raw_hist.size() > DC + 2) void'(raw_hist.pop_back());
    end
    mod_e.level = m_level;
    exp_q.push_back(mod_e);
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (btn_level == mon_e.level && btn_press == mon_e.press && btn_release == mon_e.rel)
        passed++;
      else
        $display("FAIL scoreboard t=%0t got lvl=%b prs=%b rel=%b want lvl=%b prs=%b rel=%b",
                 $time, btn_level, btn_press, btn_release, mon_e.level, mon_e.press, mon_e.rel);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (btn_level == '0 && btn_press == '0 && btn_release == '0) passed++;
    else $display("FAIL %s got lvl=%b prs=%b rel=%b want all zero", name, btn_level, btn_press, btn_release);
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got == want) passed++;
    else $display("FAIL %s got %0d want %0d", name, got, want);
  endtask

  task automatic pulse_reset(input string name);
    rst_n = 1'b0;
    #1;
    check_zero(name);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int n_press, n_rel, prob;
  logic [N-1:0] bounce_pat [10] = '{5'd1, 5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 5'd1, 5'd1, 5'd1, 5'd1};

  initial begin
    btn_raw = '1;
    repeat (3) tick();
    check_zero("reset_hold");
    rst_n = 1'b1;
    repeat (12) tick();

    btn_raw = '0;
    repeat (10) tick();
    btn_raw[1] = 1'b1;
    repeat (30) tick();
    btn_raw[1] = 1'b0;
    repeat (10) tick();

    for (int i = 0; i < 10; i++) begin
      btn_raw[0] = bounce_pat[i][0];
      tick();
    end
    repeat (10) tick();
    btn_raw[0] = 1'b0;
    repeat (10) tick();

    btn_raw[4] = 1'b1;
    repeat (3) tick();
    btn_raw[4] = 1'b0;
    repeat (10) tick();

    btn_raw[3] = 1'b1;
    repeat (4) tick();
    pulse_reset("reset_mid_count");
    repeat (10) tick();
    btn_raw[3] = 1'b0;
    repeat (10) tick();

    n_press = 0;
    n_rel = 0;
    btn_raw[2] = 1'b1;
    for (int i = 0; i < 58; i++) begin
      tick();
      n_press += int'(btn_press[2]);
      n_rel   += int'(btn_release[2]);
    end
    btn_raw[2] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      n_press += int'(btn_press[2]);
      n_rel   += int'(btn_release[2]);
    end
`ifdef BTN_AUTO_REPEAT_EN
    check_int("hold_press_count", n_press, 6);
`else
    check_int("hold_press_count", n_press, 1);
`endif
    check_int("hold_release_count", n_rel, 1);

    for (int ph = 0; ph < 12; ph++) begin
      case (ph % 3)
        0:       prob = 2;
        1:       prob = 6;
        default: prob = 14;
      endcase
      for (int c = 0; c < 250; c++) begin
        for (int b = 0; b < N; b++)
          if ($urandom_range(prob - 1) == 0) btn_raw[b] = ~btn_raw[b];
        if ($urandom_range(399) == 0) pulse_reset("reset_random");
        tick();
      end
    end

    btn_raw = '0;
    repeat (15) tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Front-end button conditioner for the board-level demo designs: it synchronizes, debounces and edge-detects raw push-button inputs. It produces clean single-cycle press/release pulses and stable levels. It sits directly upstream of the LED pattern logic and replaces the ad-hoc single-button oneshot currently feeding the "fill all LEDs" request. The centre button's debounced level also serves as the pattern logic's clear input.

## Interface
- `N_BTN`, 5, number of independent buttons (order: c, u, d, l, r).
- `DEBOUNCE_CYCLES`, 1_000_000, consecutive cycles a new input value must persist before it is accepted (10 ms at 100 MHz); legal range ≥ 2.
- `REPEAT_DELAY`, 50_000_000, hold cycles before the first auto-repeat pulse (used only with `BTN_AUTO_REPEAT_EN`).
- `REPEAT_PERIOD`, 10_000_000, cycles between subsequent auto-repeat pulses (used only with `BTN_AUTO_REPEAT_EN`); legal range ≥ 2.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `btn_raw`  in  N_BTN  raw, asynchronous, bouncing button inputs; active-high.
- `btn_level`  out  N_BTN  debounced button state.
- `btn_press`  out  N_BTN  one-cycle pulse on accepted 0→1 (and on auto-repeat).
- `btn_release`  out  N_BTN  one-cycle pulse on accepted 1→0.

## Operation
- Each bit is fully independent: own synchronizer, debounce counter, stable register and (optionally) repeat counter.
- Synchronizer: two flops, `s1`→`s2`. Both reset to 0.
- Debounce counter, width `$clog2(DEBOUNCE_CYCLES)`, reset 0. Per cycle:
  - `s2 == level`: counter ← 0. Any bounce restarts the count.
  - `s2 != level` and counter < `DEBOUNCE_CYCLES-1`: counter ← counter+1.
  - `s2 != level` and counter == `DEBOUNCE_CYCLES-1`: `level` ← `s2` and counter ← 0. `btn_press` or `btn_release` is registered high for that single cycle.
- `btn_press` and `btn_release` are registered, never both high on one bit, and always exactly one cycle wide.
- Pulses on different bits may coincide. There is no priority or cross-bit interaction.

## Timing
- Reset values: `btn_level`, `btn_press` and `btn_release` are all 0. All internal counters and synchronizer flops are 0.
- Latency: a clean raw edge first sampled by `s1` at clock edge k makes `btn_level` and the pulse output change at edge k+1+`DEBOUNCE_CYCLES`.
- A glitch or bounce lasting fewer than `DEBOUNCE_CYCLES` consecutive `s2` cycles produces no output change.
- Reset mid-count discards all progress. A button held through reset deassertion is treated as a new press: `btn_press` fires `DEBOUNCE_CYCLES`+2 cycles after reset releases.
- `rst_n` deassertion is synchronous to the board reset bridge. No output glitches during asynchronous assertion; outputs go to 0 immediately.

## Configuration
- Macro: `BTN_AUTO_REPEAT_EN`.
- Defined: each bit adds a hold counter, width `$clog2(REPEAT_DELAY+1)`, reset 0, cleared whenever `level` is 0 or on the accepted press.
  - While `level` is 1 it counts up. On reaching `REPEAT_DELAY` it emits a `btn_press` pulse and reloads to `REPEAT_DELAY-REPEAT_PERIOD`.
  - Result: first repeat `REPEAT_DELAY` cycles after the accepted press, then every `REPEAT_PERIOD` cycles until release.
  - Release cancels pending repeats. A repeat pulse never coincides with `btn_release`.
- Undefined: no hold counters are synthesized. `btn_press` fires only on accepted 0→1 transitions. The `REPEAT_*` parameters are ignored.

## Test plan
All scenarios use `N_BTN`=5, `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20 and `REPEAT_PERIOD`=8, unless noted.
- Reset: hold `rst_n`=0 with `btn_raw`=5'b11111 → all outputs 0. Release reset → `btn_press`=5'b11111 exactly 6 cycles later, for 1 cycle, and `btn_level`=5'b11111 from then on.
- Clean press/release on bit 1: raw 0→1 sampled at edge k → `btn_press[1]` high at edge k+5 only. Raw 1→0 after 30 cycles → `btn_release[1]` is one cycle, 5 edges after that sample.
- Bounce: toggle bit 0 as 1,0,1,1,1,0,1,1,1,1 cycles → no pulse until the final 4-cycle run. Then exactly one `btn_press[0]`.
- Glitch rejection: 3-cycle high pulse on bit 4 → `btn_level[4]` stays 0 and no pulses.
- Reset mid-operation: assert `rst_n` 2 cycles into a debounce count → no pulse. Outputs are 0 immediately. The count restarts from zero after release.
- With `BTN_AUTO_REPEAT_EN`: hold bit 2 for 60 cycles after acceptance → `btn_press[2]` at +0, +20, +28, +36, +44, +52. Release → one `btn_release[2]` and no further presses. Without the macro → a single `btn_press[2]`.
